// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch to instruction memory and loads the IF/ID register for decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              kill_q, kill_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   id_pc_q, id_pc_d;
    logic [XLEN-1:0]   id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;

    logic              load_c;
    logic [XLEN-1:0]   load_pc_c;
    logic [XLEN-1:0]   load_instr_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            kill_q      <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            id_pc_q     <= '0;
            id_instr_q  <= NOP_INSTR;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
        end
    end

    // Fetch FSM; a redirect overrides the PC in every state and poisons any in-flight fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        load_c       = 1'b0;
        load_pc_c    = req_pc_q;
        load_instr_c = imem_rdata;

        case (state_q)
            S_FETCH: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    kill_d   = redirect_valid;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = S_FETCH;
                    if (!kill_q && !redirect_valid) begin
                        if (stall) begin
                            buf_pc_d    = req_pc_q;
                            buf_instr_d = imem_rdata;
                            state_d     = S_HOLD;
                        end else begin
                            load_c = 1'b1;
                        end
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    buf_pc_d    = '0;
                    buf_instr_d = '0;
                    state_d     = S_FETCH;
                end else if (!stall) begin
                    load_c       = 1'b1;
                    load_pc_c    = buf_pc_q;
                    load_instr_c = buf_instr_q;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    // IF/ID register: flush beats stall beats a new instruction; otherwise a bubble.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            if (load_c) begin
                id_pc_d    = load_pc_c;
                id_instr_d = load_instr_c;
                id_valid_d = 1'b1;
            end else begin
                id_pc_d    = '0;
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
        end
    end

    assign imem_req          = (state_q == S_FETCH) && !reset;
    assign imem_addr         = pc_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_instruction = id_instr_q;
    assign if_id_valid       = id_valid_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the PC and issues fetches to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Loads the IF/ID register consumed by the decode stage.
- Obeys hazard-unit stall and flush, and accepts branch/jump redirects from EX, discarding any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on reset, flush or bubble

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
stall  input  1  hazard unit: hold IF/ID and hold fetch-side state
flush  input  1  clear IF/ID to bubble
redirect_valid  input  1  taken branch/jump from EX
redirect_pc  input  32  redirect target; bits[1:0] forced to 0
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
if_id_pc  output  32  PC of instruction in IF/ID
if_id_instruction  output  32  instruction in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async):
  - pc_q=RESET_PC, state=FETCH, kill_q=0, buf cleared.
  - if_id_pc=0, if_id_instruction=NOP_INSTR, if_id_valid=0.
  - imem_req=0 while reset is asserted.
- States:
  - FETCH: imem_req=1, imem_addr=pc_q.
    - On gnt: req_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap, 0xFFFF_FFFC+4=0), go WAIT.
  - WAIT: imem_req=0. On rvalid:
    - kill_q=1: drop data, clear kill_q, go FETCH.
    - stall=0: load IF/ID {req_pc_q, rdata, valid=1}, go FETCH.
    - stall=1: capture into buf {req_pc_q, rdata}, go HOLD.
  - HOLD: imem_req=0. When stall=0: load IF/ID from buf, go FETCH.
- Throughput: 1 instruction per 2 cycles with zero-wait memory (gnt in the request cycle, rvalid the following cycle).
- Request stability: imem_addr stays stable while imem_req=1 and gnt=0. A stall does not withdraw a pending request.
- IF/ID update priority (highest first):
  - flush: bubble (pc=0, NOP_INSTR, valid=0); any instruction arriving that cycle is discarded.
  - stall: hold.
  - New instruction available: load it.
  - Otherwise: bubble.
- Redirect (takes effect in any state, ignores stall): pc_q<={redirect_pc[31:2],2'b00}.
  - FETCH with gnt in the same cycle: granted request is stale, go WAIT with kill_q=1.
  - FETCH without gnt: stay in FETCH; the next cycle requests the new PC.
  - WAIT with rvalid in the same cycle: drop data, go FETCH.
  - WAIT without rvalid: set kill_q.
  - HOLD: discard buf, go FETCH.
  - Redirect never loads IF/ID; the core always pairs redirect with flush.
- Protocol errors: rvalid in FETCH/HOLD and gnt while imem_req=0 are ignored and cause no state change.
- Reset mid-transaction: the outstanding response is the environment's responsibility; after reset, rvalid is ignored until the first grant.

Test Plan:
- Reset release, zero-wait memory returning addr+0x100 as data -> first req addr 0x0; IF/ID gets pc 0x0/0x100, then 0x4/0x104; valid toggles 1,0 each alternate cycle.
- Memory delays gnt 3 cycles -> imem_addr held at 0x8 with req=1 for 4 cycles; pc_q advances only after gnt.
- stall=1 for 4 cycles with rvalid arriving during the stall -> IF/ID unchanged during stall; buffered word loaded on the edge after stall drops; no extra request issued while in HOLD.
- redirect_valid+flush to 0x0000_0203 while in WAIT, rvalid 2 cycles later -> late response dropped; IF/ID bubble; next req addr 0x200; the following IF/ID pc is 0x200.
- redirect in the same cycle as gnt, and separately in HOLD -> killed response never reaches IF/ID; buf discarded; fetch resumes at the target.
- pc_q=0xFFFF_FFFC fetched -> next req addr 0x0000_0000.
